exec_wb_stage: RTL and testbench

EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

---
 rtl/exec_pkg.sv | 15 +
 rtl/exec_wb_stage_if.sv | 11 +
 rtl/seq_mul.sv | 53 +++++
 rtl/exec_wb_stage.sv | 118 +++++++++++
 tb/tb_exec_wb_stage.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared opcodes, FSM encoding and width defaults for the execute/write-back stage
package exec_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_t;
endpackage

// File: rtl/exec_wb_stage_if.sv
// exec_wb_stage_if: command handshake bundle into the execute/write-back stage
interface exec_wb_stage_if import exec_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic [ADDR_W-1:0] in_sr1;
   logic [ADDR_W-1:0] in_sr2;
   logic [ADDR_W-1:0] in_dr;
   modport master (output in_valid, in_op, in_sr1, in_sr2, in_dr, input in_ready);
   modport slave  (input in_valid, in_op, in_sr1, in_sr2, in_dr, output in_ready);
endinterface

// File: rtl/seq_mul.sv
// seq_mul: iterative shift-add multiplier, one multiplier bit per cycle, low DATA_W bits kept
module seq_mul import exec_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              done,
   output logic [DATA_W-1:0] product
);
   logic [DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
   logic [5:0]        cnt_q, cnt_d;

   // load on start, then add the shifted multiplicand for each set multiplier bit
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (start) begin
         acc_d    = '0;
         mcand_d  = a;
         mplier_d = b;
         cnt_d    = 6'(DATA_W);
      end else if (cnt_q != 6'd0) begin
         acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - 6'd1;
      end
   end

   // multiplier state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   // done marks the final step, so product is complete in the following cycle
   assign done    = cnt_q == 6'd1;
   assign product = acc_q;
endmodule

// File: rtl/exec_wb_stage.sv
// exec_wb_stage: single-command execute stage reading two registers and writing one result back
module exec_wb_stage import exec_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   exec_wb_stage_if.slave    cmd,
   output logic [ADDR_W-1:0] rd_sr1,
   output logic [ADDR_W-1:0] rd_sr2,
   input  logic [DATA_W-1:0] rd_data1,
   input  logic [DATA_W-1:0] rd_data2,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_dr,
   output logic [DATA_W-1:0] wr_data,
   output logic              done,
   output logic              err,
   output logic              busy
);
   state_t            state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [ADDR_W-1:0] sr1_q, sr1_d, sr2_q, sr2_d, dr_q, dr_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, wr_data_q, wr_data_d;
   logic [DATA_W-1:0] alu, mul_p;
   logic              mul_done, illegal;

   assign illegal = op_q > OP_MUL;

   seq_mul #(.DATA_W(DATA_W)) u_mul (
      .clk(clk), .reset(reset), .start(state_q == S_EXEC && op_q == OP_MUL),
      .a(a_q), .b(b_q), .done(mul_done), .product(mul_p)
   );

   // single-cycle ALU on the latched operands
   always_comb begin
      alu = '0;
      case (op_q)
         OP_ADD: alu = a_q + b_q;
         OP_SUB: alu = a_q - b_q;
         OP_AND: alu = a_q & b_q;
         OP_OR:  alu = a_q | b_q;
         OP_XOR: alu = a_q ^ b_q;
         OP_SLT: alu = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
         OP_SLL: alu = a_q << b_q[4:0];
         OP_SRL: alu = a_q >> b_q[4:0];
         default: alu = '0;
      endcase
   end

   // sequencing and outputs; reset masks every strobe so an aborted command never writes
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      sr1_d        = sr1_q;
      sr2_d        = sr2_q;
      dr_d         = dr_q;
      a_d          = a_q;
      b_d          = b_q;
      res_d        = res_q;
      cmd.in_ready = state_q == S_IDLE && !reset;
      busy         = state_q != S_IDLE && !reset;
      done         = state_q == S_WB && !reset;
      err          = done && illegal;
      wr_en        = done && !illegal;
      wr_data      = wr_en ? (op_q == OP_MUL ? mul_p : res_q) : wr_data_q;
      wr_data_d    = wr_data;
      case (state_q)
         S_IDLE: if (cmd.in_valid) begin
            op_d    = cmd.in_op;
            sr1_d   = cmd.in_sr1;
            sr2_d   = cmd.in_sr2;
            dr_d    = cmd.in_dr;
            state_d = S_READ;
         end
         S_READ: begin
            a_d     = rd_data1;
            b_d     = rd_data2;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            res_d   = alu;
            state_d = op_q == OP_MUL ? S_MUL : S_WB;
         end
         S_MUL:  state_d = mul_done ? S_WB : S_MUL;
         S_WB:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         sr1_q     <= '0;
         sr2_q     <= '0;
         dr_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         sr1_q     <= sr1_d;
         sr2_q     <= sr2_d;
         dr_q      <= dr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign rd_sr1 = sr1_q;
   assign rd_sr2 = sr2_q;
   assign wr_dr  = dr_q;
endmodule

// File: tb/tb_exec_wb_stage.sv
// tb_exec_wb_stage: directed vectors plus handshake and reset-abort sequences against a register bank
module tb_exec_wb_stage;
   import exec_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rd_sr1, rd_sr2, wr_dr;
   logic [31:0] rd_data1, rd_data2, wr_data;
   logic        wr_en, done, err, busy;
   logic        pre = 1'b0;
   logic [31:0] bank [32];
   int          checks = 0;
   int          failures = 0;

   exec_wb_stage_if #(.ADDR_W(5)) cmd ();

   exec_wb_stage dut (
      .clk(clk), .reset(reset), .cmd(cmd),
      .rd_sr1(rd_sr1), .rd_sr2(rd_sr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .wr_en(wr_en), .wr_dr(wr_dr), .wr_data(wr_data),
      .done(done), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(int k);
      case (k)
         20: return 32'd1;
         21: return 32'd35;
         22: return 32'hFFFF_FFFF;
         23: return 32'd2;
         default: return 32'(10 * k);
      endcase
   endfunction

   always @(posedge clk) begin
      if (pre) for (int k = 0; k < 32; k++) bank[k] <= init_val(k);
      else if (wr_en) bank[wr_dr] <= wr_data;
   end

   assign rd_data1 = bank[rd_sr1];
   assign rd_data2 = bank[rd_sr2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic preload();
      @(negedge clk) pre = 1'b1;
      @(negedge clk) pre = 1'b0;
   endtask

   task automatic drive(input logic [3:0] op, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
      cmd.in_valid = 1'b1;
      cmd.in_op    = op;
      cmd.in_sr1   = s1;
      cmd.in_sr2   = s2;
      cmd.in_dr    = d;
   endtask

   // lat counts rising edges from the accept edge to the cycle where done is seen
   task automatic run_cmd(input logic [3:0] op, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          output int lat, output logic ok, output logic wen, output logic [31:0] data,
                          output logic [4:0] wdr, output logic e);
      int g = 0;
      @(negedge clk);
      while (!cmd.in_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      drive(op, s1, s2, d);
      @(posedge clk);
      @(negedge clk);
      cmd.in_valid = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      ok   = done;
      wen  = wr_en;
      data = wr_data;
      wdr  = wr_dr;
      e    = err;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [4:0]  s1, s2, d;
      logic        wen;
      logic [31:0] data;
      logic        e;
      int          lat;
   } vec_t;

   vec_t        v [16];
   int          lat, n;
   logic        ok, wen, e, wen_seen;
   logic [31:0] data;
   logic [4:0]  wdr;

   initial begin
      // ALU ops occupy accept, READ, EXEC, WB: done three edges after the accept edge
      v[0]  = '{OP_ADD, 5'd3,  5'd4,  5'd5,  1'b1, 32'd70,          1'b0, 3};
      v[1]  = '{OP_SUB, 5'd2,  5'd9,  5'd31, 1'b1, 32'hFFFF_FFBA,   1'b0, 3};
      v[2]  = '{OP_SLT, 5'd2,  5'd9,  5'd31, 1'b1, 32'd1,           1'b0, 3};
      v[3]  = '{OP_SLL, 5'd20, 5'd21, 5'd6,  1'b1, 32'd8,           1'b0, 3};
      v[4]  = '{OP_SRL, 5'd22, 5'd23, 5'd6,  1'b1, 32'h3FFF_FFFF,   1'b0, 3};
      v[5]  = '{OP_AND, 5'd22, 5'd7,  5'd8,  1'b1, 32'd70,          1'b0, 3};
      v[6]  = '{OP_OR,  5'd3,  5'd4,  5'd8,  1'b1, 32'd62,          1'b0, 3};
      v[7]  = '{OP_XOR, 5'd3,  5'd4,  5'd8,  1'b1, 32'd54,          1'b0, 3};
      v[8]  = '{OP_SLT, 5'd22, 5'd23, 5'd8,  1'b1, 32'd1,           1'b0, 3};
      v[9]  = '{OP_SLT, 5'd9,  5'd2,  5'd8,  1'b1, 32'd0,           1'b0, 3};
      v[10] = '{OP_MUL, 5'd7,  5'd9,  5'd1,  1'b1, 32'd6300,        1'b0, 35};
      v[11] = '{OP_MUL, 5'd22, 5'd23, 5'd2,  1'b1, 32'hFFFF_FFFE,   1'b0, 35};
      v[12] = '{4'd12,  5'd3,  5'd4,  5'd5,  1'b0, 32'd0,           1'b1, 3};
      v[13] = '{OP_ADD, 5'd1,  5'd2,  5'd0,  1'b1, 32'd30,          1'b0, 3};
      v[14] = '{OP_ADD, 5'd5,  5'd5,  5'd5,  1'b1, 32'd100,         1'b0, 3};
      v[15] = '{4'd15,  5'd1,  5'd2,  5'd9,  1'b0, 32'd0,           1'b1, 3};
      cmd.in_valid = 1'b0;
      cmd.in_op = '0;
      cmd.in_sr1 = '0;
      cmd.in_sr2 = '0;
      cmd.in_dr = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(cmd.in_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      chk("rst_rd_sr1", 32'(rd_sr1), 32'd0);
      chk("rst_rd_sr2", 32'(rd_sr2), 32'd0);
      for (int i = 0; i < 16; i++) begin
         preload();
         run_cmd(v[i].op, v[i].s1, v[i].s2, v[i].d, lat, ok, wen, data, wdr, e);
         chk($sformatf("v%0d_done", i), 32'(ok), 32'd1);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].lat));
         chk($sformatf("v%0d_wr_en", i), 32'(wen), 32'(v[i].wen));
         chk($sformatf("v%0d_err", i), 32'(e), 32'(v[i].e));
         if (v[i].wen) begin
            chk($sformatf("v%0d_wr_dr", i), 32'(wdr), 32'(v[i].d));
            chk($sformatf("v%0d_wr_data", i), data, v[i].data);
         end
         @(negedge clk);
         chk($sformatf("v%0d_bank", i), bank[v[i].d], v[i].wen ? v[i].data : init_val(int'(v[i].d)));
         chk($sformatf("v%0d_idle_done", i), 32'(done), 32'd0);
      end
      // in_valid held through a busy command: the second command waits for the cycle after done
      preload();
      @(negedge clk);
      drive(OP_ADD, 5'd3, 5'd4, 5'd5);
      @(posedge clk);
      @(negedge clk);
      drive(OP_SUB, 5'd4, 5'd3, 5'd6);
      chk("hold_err_busy", 32'(err), 32'd0);
      n = 1;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("hold_lat1", 32'(n), 32'd3);
      chk("hold_ready_at_done", 32'(cmd.in_ready), 32'd0);
      chk("hold_data1", wr_data, 32'd70);
      @(negedge clk);
      chk("hold_ready_after", 32'(cmd.in_ready), 32'd1);
      chk("hold_busy_after", 32'(busy), 32'd0);
      @(posedge clk);
      @(negedge clk);
      cmd.in_valid = 1'b0;
      chk("hold_busy2", 32'(busy), 32'd1);
      n = 1;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("hold_done2", 32'(done), 32'd1);
      chk("hold_wr_dr2", 32'(wr_dr), 32'd6);
      chk("hold_data2", wr_data, 32'd10);
      @(negedge clk);
      chk("hold_bank5", bank[5], 32'd70);
      chk("hold_bank6", bank[6], 32'd10);
      // reset during the tenth MUL cycle aborts the write
      preload();
      @(negedge clk);
      drive(OP_MUL, 5'd7, 5'd9, 5'd1);
      @(posedge clk);
      @(negedge clk);
      cmd.in_valid = 1'b0;
      repeat (11) @(negedge clk);
      chk("abort_busy_mul", 32'(busy), 32'd1);
      chk("abort_done_mul", 32'(done), 32'd0);
      chk("abort_err_mul", 32'(err), 32'd0);
      reset = 1'b1;
      #1 wen_seen = wr_en;
      @(negedge clk);
      reset = 1'b0;
      #1 wen_seen = wen_seen | wr_en;
      @(negedge clk);
      chk("abort_ready", 32'(cmd.in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (40) begin
         @(negedge clk);
         wen_seen = wen_seen | wr_en;
      end
      chk("abort_no_write", 32'(wen_seen), 32'd0);
      chk("abort_bank1", bank[1], 32'd10);
      run_cmd(OP_ADD, 5'd3, 5'd4, 5'd5, lat, ok, wen, data, wdr, e);
      chk("post_abort_done", 32'(ok), 32'd1);
      chk("post_abort_data", data, 32'd70);
      chk("post_abort_lat", 32'(lat), 32'd3);
      // reset and in_valid together: nothing accepted
      @(negedge clk);
      reset = 1'b1;
      drive(OP_ADD, 5'd3, 5'd4, 5'd5);
      @(negedge clk);
      reset = 1'b0;
      cmd.in_valid = 1'b0;
      #1;
      chk("rstv_busy", 32'(busy), 32'd0);
      chk("rstv_ready", 32'(cmd.in_ready), 32'd1);
      repeat (5) @(negedge clk);
      chk("rstv_no_done", 32'(done), 32'd0);
      chk("rstv_busy_later", 32'(busy), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
